pipe_hazard_ctrl: RTL and testbench

- Sequences the ID/EX pipeline register and the stages around it in the 5-stage pipelined CPU.
- Produces the forwarding selects for the two ID-stage operands, the load-use interlock, and the multi-cycle mul/div stall FSM.
- Generates the IF/ID flush, the PC and IF/ID write enable, and the bubble request that zeroes the control fields entering ID/EX.
- Keeps saturating stall and event counters for performance debug.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_hazard_ctrl_fwd_sel.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: operand forward selects
// and the mul/div sequencing FSM states.
package pipe_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EXE = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_LD  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } md_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Operand forward-select for one ID-stage source register; EX wins over MEM,
// and register 0 is never forwarded.
module fwd_sel
   import pipe_pkg::*;
(
   input  logic [4:0] src,
   input  logic [4:0] ern,
   input  logic       ewreg,
   input  logic       em2reg,
   input  logic [4:0] mrn,
   input  logic       mwreg,
   input  logic       mm2reg,
   output logic [1:0] sel
);

   logic ex_hit;
   logic mem_hit;

   assign ex_hit  = ewreg && (ern != 5'd0) && (ern == src);
   assign mem_hit = mwreg && (mrn != 5'd0) && (mrn == src);

   // A load still in EX has no data yet, so it falls through to the MEM check.
   always_comb begin
      sel = FWD_RF;
      if (ex_hit && !em2reg)
         sel = FWD_EXE;
      else if (mem_hit)
         sel = mm2reg ? FWD_LD : FWD_MEM;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID/EX hazard control: operand forwarding, load-use interlock, multi-cycle
// mul/div stall sequencing, branch flush and saturating stall counters.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic [4:0]       rs,
   input  logic [4:0]       rt,
   input  logic             use_rs,
   input  logic             use_rt,
   input  logic             dmdiv,
   input  logic             dtaken,
   input  logic [4:0]       ern,
   input  logic             ewreg,
   input  logic             em2reg,
   input  logic [4:0]       mrn,
   input  logic             mwreg,
   input  logic             mm2reg,
   output logic [1:0]       fwda,
   output logic [1:0]       fwdb,
   output logic             wpcir,
   output logic             bubble,
   output logic             flush,
   output logic             md_start,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] lu_cnt
);

   localparam logic [3:0]       CNT_INIT = 4'(MD_LAT - 2);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   md_state_t  state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic       lu;
   logic       md_stall;
   logic       stall;

   fwd_sel u_fwd_a (
      .src    (rs),
      .ern    (ern),
      .ewreg  (ewreg),
      .em2reg (em2reg),
      .mrn    (mrn),
      .mwreg  (mwreg),
      .mm2reg (mm2reg),
      .sel    (fwda)
   );

   fwd_sel u_fwd_b (
      .src    (rt),
      .ern    (ern),
      .ewreg  (ewreg),
      .em2reg (em2reg),
      .mrn    (mrn),
      .mwreg  (mwreg),
      .mm2reg (mm2reg),
      .sel    (fwdb)
   );

   assign lu = ewreg && em2reg && (ern != 5'd0) &&
               ((use_rs && (ern == rs)) || (use_rt && (ern == rt)));

   // NOTE: every output of this block gets a default first so no path leaves a
   // latch behind.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      md_start = 1'b0;
      case (state)
         IDLE: begin
            if (dmdiv && !lu) begin
               state_nx = BUSY;
               cnt_nx   = CNT_INIT;
               md_start = 1'b1;
            end
         end
         BUSY: begin
            if (cnt == 4'd0)
               state_nx = DONE;
            else
               cnt_nx = cnt - 4'd1;
         end
         // The instruction advances here; dmdiv is still high but must not retrigger.
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments and an asynchronous
   // reset so a mid-operation reset aborts immediately, without a clock edge.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   assign md_stall = ((state == IDLE) && dmdiv && !lu) || (state == BUSY);
   assign stall    = lu || md_stall;
   assign wpcir    = !stall;
   assign bubble   = stall;
   assign md_busy  = (state != IDLE);
   assign flush    = dtaken && !stall;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         stall_cnt <= '0;
         lu_cnt    <= '0;
      end else begin
         if (stall && (stall_cnt != CNT_MAX))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (lu && (lu_cnt != CNT_MAX))
            lu_cnt <= lu_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MD_LAT=4, CNT_W=4): forwarding, load-use,
// mul/div sequencing, branch flush, asynchronous reset and counter saturation.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       clrn;
   logic [4:0] rs, rt, ern, mrn;
   logic       use_rs, use_rt, dmdiv, dtaken;
   logic       ewreg, em2reg, mwreg, mm2reg;
   logic [1:0] fwda, fwdb;
   logic       wpcir, bubble, flush, md_start, md_busy;
   logic [3:0] stall_cnt, lu_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) dut (
      .clk       (clk),
      .clrn      (clrn),
      .rs        (rs),
      .rt        (rt),
      .use_rs    (use_rs),
      .use_rt    (use_rt),
      .dmdiv     (dmdiv),
      .dtaken    (dtaken),
      .ern       (ern),
      .ewreg     (ewreg),
      .em2reg    (em2reg),
      .mrn       (mrn),
      .mwreg     (mwreg),
      .mm2reg    (mm2reg),
      .fwda      (fwda),
      .fwdb      (fwdb),
      .wpcir     (wpcir),
      .bubble    (bubble),
      .flush     (flush),
      .md_start  (md_start),
      .md_busy   (md_busy),
      .stall_cnt (stall_cnt),
      .lu_cnt    (lu_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      rs = 5'd0; rt = 5'd0; ern = 5'd0; mrn = 5'd0;
      use_rs = 1'b0; use_rt = 1'b0; dmdiv = 1'b0; dtaken = 1'b0;
      ewreg = 1'b0; em2reg = 1'b0; mwreg = 1'b0; mm2reg = 1'b0;
   endtask

   // Moves to 2 time units after the next rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   // Short reset pulse between edges; leaves the bench 3 units after an edge.
   task automatic apply_reset();
      next_cycle();
      clear_inputs();
      clrn = 1'b0;
      #1;
      clrn = 1'b1;
   endtask

   logic [5:0] exp_start3, exp_stall3, exp_busy3, exp_flush5;
   logic [6:0] exp_start4, exp_stall4;

   initial begin
      exp_start3 = 6'b000001;
      exp_stall3 = 6'b001111;
      exp_busy3  = 6'b011110;
      exp_start4 = 7'b0000010;
      exp_stall4 = 7'b0011111;
      exp_flush5 = 6'b010000;

      // Reset state
      clear_inputs();
      clrn = 1'b0;
      #3;
      check("rst_busy",  md_busy,   0);
      check("rst_stcnt", stall_cnt, 0);
      check("rst_lucnt", lu_cnt,    0);
      check("rst_wpcir", wpcir,     1);
      check("rst_start", md_start,  0);
      check("rst_fwda",  fwda,      0);
      next_cycle();
      clrn = 1'b1;

      // Forwarding selects
      rs = 5'd5; ern = 5'd5; ewreg = 1'b1; em2reg = 1'b0;
      #1 check("fwd_ex", fwda, 2'b01);
      check("fwd_ex_nolu", wpcir, 1);
      mrn = 5'd5; mwreg = 1'b1;
      #1 check("fwd_ex_prio", fwda, 2'b01);
      em2reg = 1'b1;
      #1 check("fwd_ex_load_to_mem", fwda, 2'b10);
      mm2reg = 1'b1;
      #1 check("fwd_ex_load_to_ld", fwda, 2'b11);
      clear_inputs();
      ern = 5'd0; rs = 5'd0; ewreg = 1'b1; mrn = 5'd0; mwreg = 1'b1;
      #1 check("fwd_r0", fwda, 2'b00);
      rt = 5'd7; ern = 5'd3; mrn = 5'd7; mm2reg = 1'b0;
      #1 check("fwdb_mem", fwdb, 2'b10);
      check("fwda_none", fwda, 2'b00);
      mm2reg = 1'b1;
      #1 check("fwdb_ld", fwdb, 2'b11);
      clear_inputs();
      rt = 5'd9; ern = 5'd9; ewreg = 1'b1;
      #1 check("fwdb_ex_ungated", fwdb, 2'b01);
      mwreg = 1'b0; ewreg = 1'b0;
      #1 check("fwdb_nowreg", fwdb, 2'b00);

      // Load-use interlock, one cycle, then the load is forwarded from MEM
      apply_reset();
      ern = 5'd8; ewreg = 1'b1; em2reg = 1'b1; rt = 5'd8; use_rt = 1'b1; dtaken = 1'b1;
      #1;
      check("lu_wpcir",  wpcir,  0);
      check("lu_bubble", bubble, 1);
      check("lu_flush",  flush,  0);
      check("lu_start",  md_start, 0);
      check("lu_cnt0",   lu_cnt, 0);
      next_cycle();
      check("lu_cnt1",   lu_cnt, 1);
      ern = 5'd0; ewreg = 1'b0; em2reg = 1'b0; mrn = 5'd8; mwreg = 1'b1; mm2reg = 1'b1;
      #1;
      check("lu_rel_wpcir",  wpcir,  1);
      check("lu_rel_bubble", bubble, 0);
      check("lu_rel_flush",  flush,  1);
      check("lu_fwdb_ld",    fwdb,   2'b11);
      next_cycle();
      check("lu_cnt_hold",   lu_cnt,    1);
      check("lu_stall_cnt",  stall_cnt, 1);

      // Load-use when the instruction does not read the register
      use_rt = 1'b0; ern = 5'd8; ewreg = 1'b1; em2reg = 1'b1;
      #1 check("lu_unused", wpcir, 1);

      // Mul/div sequence
      apply_reset();
      for (int c = 0; c < 6; c++) begin
         dmdiv = (c <= 4);
         #1;
         check($sformatf("md_start_c%0d", c), md_start, exp_start3[c]);
         check($sformatf("md_stall_c%0d", c), bubble,   exp_stall3[c]);
         check($sformatf("md_wpcir_c%0d", c), wpcir,    !exp_stall3[c]);
         check($sformatf("md_busy_c%0d",  c), md_busy,  exp_busy3[c]);
         next_cycle();
      end
      check("md_stall_cnt", stall_cnt, 4);
      check("md_lu_cnt",    lu_cnt,    0);

      // Load-use and mul/div together
      apply_reset();
      ern = 5'd8; ewreg = 1'b1; em2reg = 1'b1; rt = 5'd8; use_rt = 1'b1;
      for (int c = 0; c < 7; c++) begin
         if (c == 1) begin
            ern = 5'd0; ewreg = 1'b0; em2reg = 1'b0;
            mrn = 5'd8; mwreg = 1'b1; mm2reg = 1'b1;
         end
         dmdiv = (c <= 5);
         #1;
         check($sformatf("lumd_start_c%0d", c), md_start, exp_start4[c]);
         check($sformatf("lumd_stall_c%0d", c), bubble,   exp_stall4[c]);
         next_cycle();
      end
      check("lumd_stall_cnt", stall_cnt, 5);
      check("lumd_lu_cnt",    lu_cnt,    1);

      // Taken branch held during mul/div
      apply_reset();
      for (int c = 0; c < 6; c++) begin
         dmdiv  = (c <= 4);
         dtaken = (c <= 4);
         #1;
         check($sformatf("br_flush_c%0d", c), flush, exp_flush5[c]);
         next_cycle();
      end

      // Asynchronous reset mid-BUSY
      apply_reset();
      dmdiv = 1'b1;
      next_cycle();
      next_cycle();
      #1;
      check("arst_pre_busy",  md_busy,   1);
      check("arst_pre_stcnt", stall_cnt, 2);
      dmdiv = 1'b0;
      clrn  = 1'b0;
      #1;
      check("arst_busy",  md_busy,   0);
      check("arst_stcnt", stall_cnt, 0);
      check("arst_lucnt", lu_cnt,    0);
      check("arst_wpcir", wpcir,     1);
      check("arst_start", md_start,  0);
      next_cycle();
      clrn = 1'b1;
      next_cycle();
      #1;
      check("arst_post_busy",  md_busy,   0);
      check("arst_post_stcnt", stall_cnt, 0);

      // Counter saturation with a 20-cycle interlock
      apply_reset();
      ern = 5'd8; ewreg = 1'b1; em2reg = 1'b1; rs = 5'd8; use_rs = 1'b1;
      repeat (14) next_cycle();
      check("sat_stcnt_14", stall_cnt, 14);
      check("sat_lucnt_14", lu_cnt,    14);
      repeat (6) next_cycle();
      check("sat_stcnt_20", stall_cnt, 15);
      check("sat_lucnt_20", lu_cnt,    15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
